// File: rtl/atomrvcore_idu_if.sv
// atomRVCORE decode-stage bus: fetch-side handshake and decoded outputs.
// master drives the stage inputs, slave is the decode stage itself.
interface atomrvcore_idu_if #(
  parameter int DATAWIDTH = 32
);
  logic                 flush_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [DATAWIDTH-1:0] instruction_i;
  logic [DATAWIDTH-1:0] pc_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [DATAWIDTH-1:0] instruction_o;
  logic [DATAWIDTH-1:0] pc_o;
  logic [4:0]           rs1_o;
  logic [4:0]           rs2_o;
  logic [4:0]           rd_o;
  logic [2:0]           funct3_o;
  logic                 funct7b5_o;
  logic [DATAWIDTH-1:0] immed_o;
  logic                 BE_o;
  logic                 JALRE_o;
  logic                 UJE_o;
  logic                 U_EN_o;
  logic                 LUI_EN_o;
  logic                 load_o;
  logic                 store_o;
  logic                 regwrite_o;
  logic                 illegal_o;

  modport slave (
    input  flush_i, valid_i, instruction_i, pc_i, ready_i,
    output ready_o, valid_o, instruction_o, pc_o,
    output rs1_o, rs2_o, rd_o, funct3_o, funct7b5_o, immed_o,
    output BE_o, JALRE_o, UJE_o, U_EN_o, LUI_EN_o,
    output load_o, store_o, regwrite_o, illegal_o
  );

  modport master (
    output flush_i, valid_i, instruction_i, pc_i, ready_i,
    input  ready_o, valid_o, instruction_o, pc_o,
    input  rs1_o, rs2_o, rd_o, funct3_o, funct7b5_o, immed_o,
    input  BE_o, JALRE_o, UJE_o, U_EN_o, LUI_EN_o,
    input  load_o, store_o, regwrite_o, illegal_o
  );
endinterface

// File: rtl/atomrvcore_idu.sv
// atomRVCORE RV32I decode stage, registered behind valid/ready.
// ATOMRV_IDU_SKID_EN adds a 1-entry skid buffer and a registered ready_o.
module atomrvcore_idu #(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input logic             clk_i,
  input logic             PCrst_i,
  atomrvcore_idu_if.slave bus
);
  typedef struct packed {
    logic [DATAWIDTH-1:0] instr;
    logic [DATAWIDTH-1:0] pc;
    logic [DATAWIDTH-1:0] imm;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [2:0]           f3;
    logic                 f7b5;
    logic                 be;
    logic                 jalre;
    logic                 uje;
    logic                 u_en;
    logic                 lui_en;
    logic                 load;
    logic                 store;
    logic                 regwrite;
    logic                 illegal;
  } dec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic dec_t idle();
    dec_t d;
    d       = '0;
    d.instr = NOP_INSTR;
    return d;
  endfunction

  logic [DATAWIDTH-1:0] ins;
  logic [6:0]           op;
  logic [DATAWIDTH-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  dec_t                 dec;
  dec_t                 q;
  logic                 v;

  assign ins = bus.instruction_i;
  assign op  = ins[6:0];

  assign imm_i = {{(DATAWIDTH-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(DATAWIDTH-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(DATAWIDTH-11){ins[31]}}, ins[7], ins[30:25],
                  ins[11:8]};
  assign imm_j = {{(DATAWIDTH-19){ins[31]}}, ins[19:12], ins[20],
                  ins[30:21]};
  assign imm_u = {{(DATAWIDTH-20){ins[31]}}, ins[31:12]};

  // combinational opcode decode of the incoming instruction
  always_comb begin
    dec       = '0;
    dec.instr = ins;
    dec.pc    = bus.pc_i;
    dec.rs1   = ins[19:15];
    dec.rs2   = ins[24:20];
    dec.rd    = ins[11:7];
    dec.f3    = ins[14:12];
    dec.f7b5  = ins[30];
    unique case (1'b1)
      op == OP_R: dec.regwrite = 1'b1;
      op == OP_I: begin
        dec.imm      = imm_i;
        dec.regwrite = 1'b1;
      end
      op == OP_LOAD: begin
        dec.imm      = imm_i;
        dec.load     = 1'b1;
        dec.regwrite = 1'b1;
      end
      op == OP_STORE: begin
        dec.imm   = imm_s;
        dec.store = 1'b1;
      end
      op == OP_BRANCH: begin
        dec.imm = imm_b;
        dec.be  = 1'b1;
      end
      op == OP_JALR: begin
        dec.imm      = imm_i;
        dec.jalre    = 1'b1;
        dec.regwrite = 1'b1;
      end
      op == OP_JAL: begin
        dec.imm      = imm_j;
        dec.uje      = 1'b1;
        dec.regwrite = 1'b1;
      end
      op == OP_LUI: begin
        dec.imm      = imm_u;
        dec.lui_en   = 1'b1;
        dec.regwrite = 1'b1;
      end
      op == OP_AUIPC: begin
        dec.imm      = imm_u;
        dec.u_en     = 1'b1;
        dec.regwrite = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.regwrite = 1'b0;
  end

`ifdef ATOMRV_IDU_SKID_EN
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  dec_t   skid;
  logic   rdy;

  // EMPTY/FULL skid FSM; ready is a flop so ready_i never reaches ready_o
  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      state <= EMPTY;
      rdy   <= 1'b1;
      skid  <= '0;
      q     <= idle();
      v     <= 1'b0;
    end else if (bus.flush_i) begin
      state <= EMPTY;
      rdy   <= 1'b1;
      q     <= idle();
      v     <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (bus.valid_i) begin
            if (v && !bus.ready_i) begin
              skid  <= dec;
              state <= FULL;
              rdy   <= 1'b0;
            end else begin
              q <= dec;
              v <= 1'b1;
            end
          end else if (bus.ready_i) begin
            v <= 1'b0;
          end
        end
        FULL: begin
          if (bus.ready_i) begin
            q     <= skid;
            v     <= 1'b1;
            state <= EMPTY;
            rdy   <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.ready_o = rdy & PCrst_i;
`else
  logic ready;

  assign ready       = (!v || bus.ready_i) & PCrst_i;
  assign bus.ready_o = ready;

  // main output register: flush, then accept, then drain on ready_i
  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      q <= idle();
      v <= 1'b0;
    end else if (bus.flush_i) begin
      q <= idle();
      v <= 1'b0;
    end else if (bus.valid_i && ready) begin
      q <= dec;
      v <= 1'b1;
    end else if (bus.ready_i) begin
      v <= 1'b0;
    end
  end
`endif

  assign bus.valid_o       = v;
  assign bus.instruction_o = q.instr;
  assign bus.pc_o          = q.pc;
  assign bus.immed_o       = q.imm;
  assign bus.rs1_o         = q.rs1;
  assign bus.rs2_o         = q.rs2;
  assign bus.rd_o          = q.rd;
  assign bus.funct3_o      = q.f3;
  assign bus.funct7b5_o    = q.f7b5;
  assign bus.BE_o          = q.be;
  assign bus.JALRE_o       = q.jalre;
  assign bus.UJE_o         = q.uje;
  assign bus.U_EN_o        = q.u_en;
  assign bus.LUI_EN_o      = q.lui_en;
  assign bus.load_o        = q.load;
  assign bus.store_o       = q.store;
  assign bus.regwrite_o    = q.regwrite;
  assign bus.illegal_o     = q.illegal;
endmodule

// File: tb/tb_atomrvcore_idu.sv
// Scoreboard bench for atomrvcore_idu: random RV32I stream vs model.
// Works with and without ATOMRV_IDU_SKID_EN.
module tb_atomrvcore_idu;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  atomrvcore_idu_if #(.DATAWIDTH(32)) bus ();

  atomrvcore_idu dut (
    .clk_i  (clk),
    .PCrst_i(rst_n),
    .bus    (bus)
  );

`ifdef ATOMRV_IDU_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic [8:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V encoding rules, offsets halved for fetch adders
  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] pc);
    exp_t e;
    int   val;
    logic signed [12:0] boff;
    logic signed [20:0] joff;
    logic be, jr, jl, au, lu, ld, st, wr, il;
    e = '0;
    val = 0;
    {be, jr, jl, au, lu, ld, st, wr, il} = '0;
    e.instr = i;
    e.pc    = pc;
    e.rs1   = i[19:15];
    e.rs2   = i[24:20];
    e.rd    = i[11:7];
    e.f3    = i[14:12];
    e.f7    = i[30];
    boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    joff = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'h33: wr = 1;
      7'h13: begin wr = 1; val = $signed(i[31:20]); end
      7'h03: begin wr = 1; ld = 1; val = $signed(i[31:20]); end
      7'h23: begin st = 1; val = $signed({i[31:25], i[11:7]}); end
      7'h63: begin be = 1; val = boff / 2; end
      7'h67: begin wr = 1; jr = 1; val = $signed(i[31:20]); end
      7'h6F: begin wr = 1; jl = 1; val = joff / 2; end
      7'h37: begin wr = 1; lu = 1; val = $signed(i[31:12]); end
      7'h17: begin wr = 1; au = 1; val = $signed(i[31:12]); end
      default: il = 1;
    endcase
    if (i[11:7] == 5'd0) wr = 0;
    e.imm   = val;
    e.flags = {be, jr, jl, au, lu, ld, st, wr, il};
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.instr = bus.instruction_o;
    a.pc    = bus.pc_o;
    a.imm   = bus.immed_o;
    a.rs1   = bus.rs1_o;
    a.rs2   = bus.rs2_o;
    a.rd    = bus.rd_o;
    a.f3    = bus.funct3_o;
    a.f7    = bus.funct7b5_o;
    a.flags = {bus.BE_o, bus.JALRE_o, bus.UJE_o, bus.U_EN_o,
               bus.LUI_EN_o, bus.load_o, bus.store_o,
               bus.regwrite_o, bus.illegal_o};
    return a;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                            7'h67, 7'h6F, 7'h37, 7'h17};
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = ops[k];
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  // Monitor: every valid&&ready before an edge is one transfer
  initial begin
    exp_t a, e;
    forever begin
      @(negedge clk);
      #3;
      if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
        a = actual();
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected none", a);
        end else begin
          e = sb.pop_front();
          check("xfer", a, e);
        end
      end
    end
  end

  task automatic cyc(input logic vi, input logic [31:0] ins,
                     input logic [31:0] pc, input logic rdy,
                     input logic fl, output logic acc);
    @(negedge clk);
    bus.valid_i       = vi;
    bus.instruction_i = ins;
    bus.pc_i          = pc;
    bus.ready_i       = rdy;
    bus.flush_i       = fl;
    #2;
    acc = vi && (bus.ready_o === 1'b1) && !fl && rst_n;
    if (fl) sb.delete();
    else if (acc) sb.push_back(model(ins, pc));
  endtask

  task automatic idle_state(input string tag);
    check({tag, "_valid"}, bus.valid_o, 0);
    check({tag, "_instr"}, bus.instruction_o, 32'h13);
    check({tag, "_flags"}, actual().flags, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_i = 0;
    bus.ready_i = 0;
    bus.flush_i = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    check("rst_ready", bus.ready_o, 0);
    check("rst_valid", bus.valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rel_ready", bus.ready_o, 1);
    idle_state("rel");
    check("rel_pc", bus.pc_o, 0);
    check("rel_imm", bus.immed_o, 0);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 40 && (sb.size() != 0 || bus.valid_o); n++)
      cyc(0, 0, 0, 1, 0, acc);
    cyc(0, 0, 0, 1, 0, acc);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
    end
  endtask

  initial begin
    logic [31:0] dir[5] = '{32'h00A00093, 32'hFE000EE3, 32'h008000EF,
                            32'h123452B7, 32'h0000007F};
    logic [31:0] abc[3] = '{32'h00500113, 32'h002081B3, 32'h0041A023};
    logic [31:0] cur, cpc;
    logic        acc, vi, rdy, fl;
    int          idx;
    bus.valid_i       = 0;
    bus.ready_i       = 0;
    bus.flush_i       = 0;
    bus.instruction_i = 0;
    bus.pc_i          = 0;

    do_reset();

    foreach (dir[k]) begin
      acc = 0;
      for (int n = 0; n < 10 && !acc; n++)
        cyc(1, dir[k], 32'h100 + 4 * k, 1, 0, acc);
    end
    drain();

    idx = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(1, abc[idx], 32'h200 + 4 * idx, 0, 0, acc);
      if (c == 0) check("hold_a_acc", acc, 1);
      else if (c == 1) check("hold_b_acc", acc, SKID);
      else check("hold_c_acc", acc, 0);
      if (acc) idx++;
    end
    for (int n = 0; n < 20 && idx < 3; n++) begin
      cyc(1, abc[idx], 32'h200 + 4 * idx, 1, 0, acc);
      if (acc) idx++;
    end
    check("hold_all_sent", idx, 3);
    drain();

    cyc(1, 32'h00100093, 32'h300, 0, 0, acc);
    cyc(1, 32'h00200113, 32'h304, 0, 0, acc);
    check("pre_flush_b_acc", acc, SKID);
    #1;
    check("pre_flush_ready", bus.ready_o, 0);
    cyc(1, 32'h00300193, 32'h308, 0, 1, acc);
    cyc(0, 0, 0, 1, 0, acc);
    check("flush_ready", bus.ready_o, 1);
    idle_state("flush");
    drain();

    cur = rand_instr();
    cpc = 32'h1000;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
        cur = rand_instr();
      end
      vi  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      rdy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
      cyc(vi, cur, cpc, rdy, fl, acc);
      if (acc || fl) begin
        cur = rand_instr();
        cpc = cpc + 4;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
